// File: rtl/ex_stage_if.sv
// Operand-fetch -> execute -> memory-access bundle for the SimpleRisc execute stage.
// master drives operands (operand fetch side); slave is the execute stage itself.
interface ex_stage_if;
   logic        in_valid;
   logic [4:0]  opcode;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] op2_in;
   logic [3:0]  rd_in;
   logic        isWb_in;
   logic        ex_busy;
   logic        ma_valid;
   logic [31:0] Alu_Result1;
   logic [31:0] op2;
   logic        IsLd;
   logic        IsSt;
   logic        IsWb;
   logic [3:0]  rd;
   logic        flag_E;
   logic        flag_GT;

   modport master (
      output in_valid, opcode, op_a, op_b, op2_in, rd_in, isWb_in,
      input  ex_busy, ma_valid, Alu_Result1, op2, IsLd, IsSt, IsWb, rd, flag_E, flag_GT
   );

   modport slave (
      input  in_valid, opcode, op_a, op_b, op2_in, rd_in, isWb_in,
      output ex_busy, ma_valid, Alu_Result1, op2, IsLd, IsSt, IsWb, rd, flag_E, flag_GT
   );
endinterface

// File: rtl/ex_stage.sv
// SimpleRisc execute stage: single-cycle ALU, cmp flags, and a 32-step
// restoring signed divider for div/mod that stalls operand fetch while running.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   ex_stage_if.slave   bus
);

   typedef enum logic [4:0] {
      OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010, OP_DIV = 5'b00011,
      OP_MOD = 5'b00100, OP_CMP = 5'b00101, OP_AND = 5'b00110, OP_OR  = 5'b00111,
      OP_NOT = 5'b01000, OP_MOV = 5'b01001, OP_LSL = 5'b01010, OP_LSR = 5'b01011,
      OP_ASR = 5'b01100, OP_NOP = 5'b01101, OP_LD  = 5'b01110, OP_ST  = 5'b01111
   } opcode_e;

   typedef enum logic {S_IDLE, S_DIV} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic        mod_q, mod_d;
   logic [3:0]  drd_q, drd_d;
   logic        dwb_q, dwb_d;

   logic        vld_q, vld_d;
   logic [31:0] res_q, res_d;
   logic [31:0] op2_q, op2_d;
   logic        ld_q, ld_d;
   logic        st_q, st_d;
   logic        wb_q, wb_d;
   logic [3:0]  rd_q, rd_d;
   logic        fe_q, fe_d;
   logic        fgt_q, fgt_d;

   opcode_e     op;
   logic        accept;
   logic [31:0] abs_a, abs_b;
   logic [32:0] rem_sh, diff;
   logic        qbit;
   logic [31:0] rem_nx, quo_nx;
   logic [31:0] q_fix, r_fix;
   logic [31:0] alu_res;
   logic [4:0]  shamt;

   assign op     = opcode_e'(bus.opcode);
   assign accept = bus.in_valid & (state_q == S_IDLE);
   assign shamt  = bus.op_b[4:0];
   assign abs_a  = bus.op_a[31] ? -bus.op_a : bus.op_a;
   assign abs_b  = bus.op_b[31] ? -bus.op_b : bus.op_b;

   // One restoring step: shift the next dividend bit into the partial remainder.
   // Magnitudes fit in 32 bits (even 0x80000000), so the 33rd bit is the borrow.
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {1'b0, dvs_q};
   assign qbit   = ~diff[32];
   assign rem_nx = qbit ? diff[31:0] : rem_sh[31:0];
   assign quo_nx = {quo_q[30:0], qbit};
   assign q_fix  = negq_q ? -quo_nx : quo_nx;
   assign r_fix  = negr_q ? -rem_nx : rem_nx;

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD, OP_LD, OP_ST: alu_res = bus.op_a + bus.op_b;
         OP_SUB:               alu_res = bus.op_a - bus.op_b;
         OP_MUL:               alu_res = bus.op_a * bus.op_b;
         OP_AND:               alu_res = bus.op_a & bus.op_b;
         OP_OR:                alu_res = bus.op_a | bus.op_b;
         OP_NOT:               alu_res = ~bus.op_b;
         OP_MOV:               alu_res = bus.op_b;
         OP_LSL:               alu_res = bus.op_a << shamt;
         OP_LSR:               alu_res = bus.op_a >> shamt;
         OP_ASR:               alu_res = $unsigned($signed(bus.op_a) >>> shamt);
         OP_MOD:               alu_res = bus.op_a;  // only used for divisor 0
         default:              alu_res = '0;        // cmp, div by 0, nop
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      mod_d   = mod_q;
      drd_d   = drd_q;
      dwb_d   = dwb_q;
      vld_d   = 1'b0;
      ld_d    = 1'b0;
      st_d    = 1'b0;
      wb_d    = 1'b0;
      res_d   = res_q;
      op2_d   = op2_q;
      rd_d    = rd_q;
      fe_d    = fe_q;
      fgt_d   = fgt_q;

      case (state_q)
         S_DIV: begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               state_d = S_IDLE;
               cnt_d   = 5'd0;
               vld_d   = 1'b1;
               res_d   = mod_q ? r_fix : q_fix;
               wb_d    = dwb_q;
               rd_d    = drd_q;
            end
         end
         default: begin
            if (accept) begin
               case (op)
                  OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_NOT, OP_MOV,
                  OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_ST, OP_CMP: begin
                     vld_d = 1'b1;
                     res_d = alu_res;
                     op2_d = bus.op2_in;
                     rd_d  = bus.rd_in;
                     ld_d  = (op == OP_LD);
                     st_d  = (op == OP_ST);
                     wb_d  = (op == OP_CMP) ? 1'b0 : bus.isWb_in;
                     if (op == OP_CMP) begin
                        fe_d  = (bus.op_a == bus.op_b);
                        fgt_d = ($signed(bus.op_a) > $signed(bus.op_b));
                     end
                  end
                  OP_DIV, OP_MOD: begin
                     if (bus.op_b == 32'd0) begin
                        vld_d = 1'b1;
                        res_d = alu_res;
                        op2_d = bus.op2_in;
                        rd_d  = bus.rd_in;
                        wb_d  = bus.isWb_in;
                     end else begin
                        state_d = S_DIV;
                        cnt_d   = 5'd31;
                        quo_d   = abs_a;
                        rem_d   = '0;
                        dvs_d   = abs_b;
                        negq_d  = bus.op_a[31] ^ bus.op_b[31];
                        negr_d  = bus.op_a[31];
                        mod_d   = (op == OP_MOD);
                        drd_d   = bus.rd_in;
                        dwb_d   = bus.isWb_in;
                     end
                  end
                  default: ;  // nop and unused opcodes leave a bubble
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         mod_q   <= 1'b0;
         drd_q   <= '0;
         dwb_q   <= 1'b0;
         vld_q   <= 1'b0;
         res_q   <= '0;
         op2_q   <= '0;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         wb_q    <= 1'b0;
         rd_q    <= '0;
         fe_q    <= 1'b0;
         fgt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         mod_q   <= mod_d;
         drd_q   <= drd_d;
         dwb_q   <= dwb_d;
         vld_q   <= vld_d;
         res_q   <= res_d;
         op2_q   <= op2_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         wb_q    <= wb_d;
         rd_q    <= rd_d;
         fe_q    <= fe_d;
         fgt_q   <= fgt_d;
      end
   end

   assign bus.ex_busy     = (state_q == S_DIV);
   assign bus.ma_valid    = vld_q;
   assign bus.Alu_Result1 = res_q;
   assign bus.op2         = op2_q;
   assign bus.IsLd        = ld_q;
   assign bus.IsSt        = st_q;
   assign bus.IsWb        = wb_q;
   assign bus.rd          = rd_q;
   assign bus.flag_E      = fe_q;
   assign bus.flag_GT     = fgt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, cmp flags, div/mod timing and
// sign rules, ld/st controls, and reset during a division.
module tb_ex_stage;

   localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010, DIV = 5'b00011,
                          MOD = 5'b00100, CMP = 5'b00101, AND = 5'b00110, OR  = 5'b00111,
                          NOT = 5'b01000, MOV = 5'b01001, LSL = 5'b01010, LSR = 5'b01011,
                          ASR = 5'b01100, NOP = 5'b01101, LD  = 5'b01110, ST  = 5'b01111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run = 0;
   int   n_fail = 0;

   ex_stage_if u_if ();

   ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] d);
      u_if.in_valid = v;
      u_if.opcode   = op;
      u_if.op_a     = a;
      u_if.op_b     = b;
      u_if.op2_in   = d;
      u_if.rd_in    = 4'd3;
      u_if.isWb_in  = 1'b1;
   endtask

   // Issue a multi-cycle div/mod, hold an add (2+3) upstream while busy,
   // and check busy length, result, and acceptance of the held add.
   task automatic do_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int cyc;
      drive(1'b1, op, a, b, 32'd0);
      tick();
      drive(1'b1, ADD, 32'd2, 32'd3, 32'd0);
      cyc = 0;
      while (u_if.ex_busy && cyc < 40) begin
         chk({tag, "_mavalid_busy"}, {31'd0, u_if.ma_valid}, 32'd0);
         tick();
         cyc++;
      end
      chk({tag, "_busy_cycles"}, cyc, 32'd32);
      chk({tag, "_result"}, u_if.Alu_Result1, exp);
      chk({tag, "_mavalid"}, {31'd0, u_if.ma_valid}, 32'd1);
      chk({tag, "_iswb"}, {31'd0, u_if.IsWb}, 32'd1);
      tick();
      chk({tag, "_held_add"}, u_if.Alu_Result1, 32'd5);
      chk({tag, "_held_add_vld"}, {31'd0, u_if.ma_valid}, 32'd1);
   endtask

   task automatic one(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      drive(1'b1, op, a, b, 32'd0);
      tick();
      chk(tag, u_if.Alu_Result1, exp);
      chk({tag, "_vld"}, {31'd0, u_if.ma_valid}, 32'd1);
      chk({tag, "_busy"}, {31'd0, u_if.ex_busy}, 32'd0);
   endtask

   initial begin
      drive(1'b0, NOP, 32'd0, 32'd0, 32'd0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_mavalid", {31'd0, u_if.ma_valid}, 32'd0);
      chk("rst_alu", u_if.Alu_Result1, 32'd0);
      chk("rst_busy", {31'd0, u_if.ex_busy}, 32'd0);
      chk("rst_flags", {30'd0, u_if.flag_E, u_if.flag_GT}, 32'd0);

      one("add", ADD, 32'd5, 32'd7, 32'd12);
      chk("add_rd", {28'd0, u_if.rd}, 32'd3);
      one("sub", SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
      one("mul", MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
      one("mul2", MUL, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFEE);
      drive(1'b0, ADD, 32'd1, 32'd1, 32'd0);
      tick();
      chk("bubble_vld", {31'd0, u_if.ma_valid}, 32'd0);
      chk("bubble_wb", {31'd0, u_if.IsWb}, 32'd0);

      one("cmp_gt", CMP, 32'd5, 32'hFFFF_FFFD, 32'd0);
      chk("cmp_gt_flags", {30'd0, u_if.flag_E, u_if.flag_GT}, 32'd1);
      one("cmp_m1_1", CMP, 32'hFFFF_FFFF, 32'd1, 32'd0);
      chk("cmp_m1_1_flags", {30'd0, u_if.flag_E, u_if.flag_GT}, 32'd0);
      chk("cmp_iswb", {31'd0, u_if.IsWb}, 32'd0);
      one("cmp_eq", CMP, 32'd4, 32'd4, 32'd0);
      chk("cmp_eq_flags", {30'd0, u_if.flag_E, u_if.flag_GT}, 32'd2);
      one("add_after_cmp", ADD, 32'd1, 32'd1, 32'd2);
      chk("flags_hold", {30'd0, u_if.flag_E, u_if.flag_GT}, 32'd2);

      do_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      do_div("mod_m7_2", MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      do_div("div_100_7", DIV, 32'd100, 32'd7, 32'd14);
      do_div("mod_100_7", MOD, 32'd100, 32'd7, 32'd2);
      do_div("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      do_div("mod_7_m2", MOD, 32'd7, 32'hFFFF_FFFE, 32'd1);
      do_div("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      do_div("mod_ovf", MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      one("div_by0", DIV, 32'd9, 32'd0, 32'd0);
      one("mod_by0", MOD, 32'd9, 32'd0, 32'd9);

      one("ld", LD, 32'h100, 32'h4, 32'h104);
      chk("ld_isld", {30'd0, u_if.IsLd, u_if.IsSt}, 32'd2);
      drive(1'b1, ST, 32'h100, 32'h4, 32'h0000_DEAD);
      tick();
      chk("st_addr", u_if.Alu_Result1, 32'h104);
      chk("st_isst", {30'd0, u_if.IsLd, u_if.IsSt}, 32'd1);
      chk("st_op2", u_if.op2, 32'h0000_DEAD);
      one("asr", ASR, 32'h8000_0000, 32'd4, 32'hF800_0000);
      one("lsr", LSR, 32'h8000_0000, 32'd4, 32'h0800_0000);
      one("lsl", LSL, 32'd1, 32'd36, 32'h10);
      one("and", AND, 32'hF0F0, 32'hFF00, 32'hF000);
      one("or", OR, 32'hF0F0, 32'hFF00, 32'hFFF0);
      one("not", NOT, 32'd0, 32'h0F0F_0000, 32'hF0F0_FFFF);
      one("mov", MOV, 32'd7, 32'h1234, 32'h1234);
      chk("alu_ldst_clear", {30'd0, u_if.IsLd, u_if.IsSt}, 32'd0);

      drive(1'b1, NOP, 32'd1, 32'd1, 32'd0);
      tick();
      chk("nop_vld", {31'd0, u_if.ma_valid}, 32'd0);
      drive(1'b1, 5'b10001, 32'd1, 32'd1, 32'd0);
      tick();
      chk("unused_vld", {31'd0, u_if.ma_valid}, 32'd0);
      chk("unused_wb", {31'd0, u_if.IsWb}, 32'd0);

      drive(1'b1, DIV, 32'd100, 32'd7, 32'd0);
      tick();
      drive(1'b0, NOP, 32'd0, 32'd0, 32'd0);
      repeat (10) tick();
      chk("mid_div_busy", {31'd0, u_if.ex_busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {31'd0, u_if.ex_busy}, 32'd0);
      chk("abort_vld", {31'd0, u_if.ma_valid}, 32'd0);
      chk("abort_alu", u_if.Alu_Result1, 32'd0);
      chk("abort_ctrl", {28'd0, u_if.IsLd, u_if.IsSt, u_if.IsWb, u_if.flag_E}, 32'd0);
      chk("abort_rd", {28'd0, u_if.rd}, 32'd0);
      one("add_after_abort", ADD, 32'd2, 32'd3, 32'd5);
      drive(1'b0, NOP, 32'd0, 32'd0, 32'd0);
      repeat (40) tick();
      chk("no_late_div", {31'd0, u_if.ma_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
